// File: rtl/lm32_user_coproc.sv
// lm32_user_coproc
// Multi-cycle coprocessor behind the LM32 user-defined-instruction port.
// It accepts one request while idle and returns a registered result with a
// single-cycle completion strobe.
//
// Ports:
//   clk             system clock, shared with the CPU
//   rst_n           asynchronous active-low reset
//   user_valid      request level; the CPU holds it high until user_complete
//   user_opcode     [3:0] selects the operation; nonzero [10:4] is illegal
//   user_operand_0  operand A
//   user_operand_1  operand B
//   user_result     registered result; valid while user_complete=1
//   user_complete   one-cycle completion strobe (DONE state)
//   busy            high in RUN or DONE
//   illegal         pulses together with user_complete for an undefined opcode
//
// Opcodes: 0 ADD, 1 MULLO, 2 MULHU, 3 POPCNT, 4 BITREV, 5 CRC8, 6 ROTL.
module lm32_user_coproc #(
  parameter int          MUL_CYCLES = 32,
  parameter logic [31:0] CRC_POLY   = 32'hEDB88320
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        user_valid,
  input  logic [10:0] user_opcode,
  input  logic [31:0] user_operand_0,
  input  logic [31:0] user_operand_1,
  output logic [31:0] user_result,
  output logic        user_complete,
  output logic        busy,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;     // product accumulator; low word doubles as CRC register
  logic [63:0] a_q, a_d;         // multiplicand, shifted left once per iteration
  logic [31:0] b_q, b_d;         // multiplier, shifted right once per iteration
  logic [31:0] result_q, result_d;
  logic        illegal_q, illegal_d;

  // Single-cycle datapath, evaluated directly on the request inputs.
  logic [31:0] popcnt_w;
  logic [31:0] bitrev_w;
  logic [63:0] rot_w;
  logic [31:0] single_w;
  logic        req_illegal_w;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi = gi + 1) begin : g_bitrev
      assign bitrev_w[gi] = user_operand_0[31-gi];
    end
  endgenerate

  always_comb begin
    popcnt_w = '0;
    for (int i = 0; i < 32; i++) begin
      popcnt_w = popcnt_w + {31'b0, user_operand_0[i]};
    end
  end

  // The upper half of {A,A} shifted left is A rotated left.
  assign rot_w = {user_operand_0, user_operand_0} << user_operand_1[4:0];

  assign req_illegal_w = (|user_opcode[10:4]) || (user_opcode[3:0] > 4'd6);

  always_comb begin
    single_w = '0;
    if (!req_illegal_w) begin
      case (user_opcode[3:0])
        4'd0:    single_w = user_operand_0 + user_operand_1;
        4'd3:    single_w = popcnt_w;
        4'd4:    single_w = bitrev_w;
        4'd6:    single_w = rot_w[63:32];
        default: single_w = '0;
      endcase
    end
  end

  // Iterative datapath: one multiplier bit or one CRC bit per RUN cycle.
  logic [63:0] mul_acc_w;
  logic [31:0] crc_w;

  assign mul_acc_w = acc_q + (b_q[0] ? a_q : 64'd0);
  assign crc_w     = (acc_q[31:0] >> 1) ^ (acc_q[0] ? CRC_POLY : 32'd0);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (user_valid) begin
          op_d      = user_opcode[3:0];
          illegal_d = req_illegal_w;
          a_d       = {32'b0, user_operand_0};
          b_d       = user_operand_1;
          acc_d     = '0;
          if (!req_illegal_w && (user_opcode[3:0] == 4'd1 || user_opcode[3:0] == 4'd2)) begin
            cnt_d   = 6'(MUL_CYCLES);
            state_d = RUN;
          end else if (!req_illegal_w && user_opcode[3:0] == 4'd5) begin
            acc_d   = {32'b0, user_operand_0 ^ {24'b0, user_operand_1[7:0]}};
            cnt_d   = 6'd8;
            state_d = RUN;
          end else begin
            result_d = single_w;
            state_d  = DONE;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - 6'd1;
        if (op_q == 4'd5) begin
          acc_d = {32'b0, crc_w};
          if (cnt_q == 6'd1) begin
            result_d = crc_w;
            state_d  = DONE;
          end
        end else begin
          acc_d = mul_acc_w;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          if (cnt_q == 6'd1) begin
            result_d = (op_q == 4'd1) ? mul_acc_w[31:0] : mul_acc_w[63:32];
            state_d  = DONE;
          end
        end
      end
      // The request is still high here; returning to IDLE drops that tail.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign user_result   = result_q;
  assign user_complete = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign illegal       = (state_q == DONE) && illegal_q;

endmodule

// File: tb/tb_lm32_user_coproc.sv
// Testbench for lm32_user_coproc: directed requests from the test plan plus
// randomized requests checked against an arithmetic reference model.
module tb_lm32_user_coproc;

  logic        clk;
  logic        rst_n;
  logic        user_valid;
  logic [10:0] user_opcode;
  logic [31:0] user_operand_0;
  logic [31:0] user_operand_1;
  logic [31:0] user_result;
  logic        user_complete;
  logic        busy;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  lm32_user_coproc dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .user_valid     (user_valid),
    .user_opcode    (user_opcode),
    .user_operand_0 (user_operand_0),
    .user_operand_1 (user_operand_1),
    .user_result    (user_result),
    .user_complete  (user_complete),
    .busy           (busy),
    .illegal        (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_illegal(input logic [10:0] op);
    return (op[10:4] != 7'd0) || (op[3:0] > 4'd6);
  endfunction

  // Reference model: straight arithmetic from the operation definitions.
  function automatic logic [31:0] model_result(input logic [10:0] op,
                                               input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    int s;
    p = {32'b0, a} * {32'b0, b};
    r = '0;
    if (model_illegal(op)) return 32'd0;
    case (op[3:0])
      4'd0: r = a + b;
      4'd1: r = p[31:0];
      4'd2: r = p[63:32];
      4'd3: r = 32'($countones(a));
      4'd4: for (int i = 0; i < 32; i++) r[i] = a[31-i];
      4'd5: begin
        r = a ^ {24'b0, b[7:0]};
        for (int k = 0; k < 8; k++) r = (r >> 1) ^ (r[0] ? 32'hEDB88320 : 32'd0);
      end
      4'd6: begin
        s = int'(b[4:0]);
        r = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int model_latency(input logic [10:0] op);
    if (model_illegal(op)) return 1;
    if (op[3:0] == 4'd1 || op[3:0] == 4'd2) return 33;
    if (op[3:0] == 4'd5) return 9;
    return 1;
  endfunction

  // Issue one request at minimum spacing; valid stays high through DONE.
  task automatic req(input string tag, input logic [10:0] op,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int  n;
    bit  done;
    user_valid     = 1'b1;
    user_opcode    = op;
    user_operand_0 = a;
    user_operand_1 = b;
    @(posedge clk); #1;
    // Scramble the inputs after acceptance; they must not matter.
    user_opcode    = 11'($urandom);
    user_operand_0 = $urandom;
    user_operand_1 = $urandom;
    n    = 1;
    done = user_complete;
    while (!done && n < 40) begin
      check({tag, "_busy_run"}, {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
      n++;
      done = user_complete;
    end
    check({tag, "_latency"}, 32'(n), 32'(model_latency(op)));
    check({tag, "_result"}, user_result, exp);
    check({tag, "_illegal"}, {31'b0, illegal}, {31'b0, model_illegal(op)});
    check({tag, "_busy_done"}, {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    user_valid = 1'b0;
    check({tag, "_no_second_complete"}, {31'b0, user_complete}, 32'd0);
    check({tag, "_illegal_low"}, {31'b0, illegal}, 32'd0);
    check({tag, "_busy_low"}, {31'b0, busy}, 32'd0);
    check({tag, "_result_held"}, user_result, exp);
    $display("req %s op=%h a=%h b=%h result=%h latency=%0d", tag, op, a, b, user_result, n);
  endtask

  initial begin
    int         seen;
    logic [10:0] op;
    logic [31:0] a, b;

    rst_n          = 1'b0;
    user_valid     = 1'b0;
    user_opcode    = '0;
    user_operand_0 = '0;
    user_operand_1 = '0;
    repeat (3) begin
      @(posedge clk); #1;
      check("reset_outputs", {user_result[31:0]}, 32'd0);
      check("reset_flags", {29'b0, user_complete, busy, illegal}, 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed test plan
    req("add_wrap", 11'h000, 32'hFFFFFFFF, 32'd1, 32'h00000000);
    req("mullo_ff", 11'h001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    req("mulhu_ff", 11'h002, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    req("mullo_2p16", 11'h001, 32'h00010000, 32'h00010000, 32'h00000000);
    req("mulhu_2p16", 11'h002, 32'h00010000, 32'h00010000, 32'h00000001);
    req("popcnt", 11'h003, 32'hF0F0F0F1, 32'd0, 32'd17);
    req("bitrev", 11'h004, 32'h00000001, 32'd0, 32'h80000000);
    req("rotl", 11'h006, 32'h80000001, 32'd4, 32'h00000018);
    req("crc8_one", 11'h005, 32'h00000000, 32'h00000001, 32'h77073096);
    req("crc8_ff", 11'h005, 32'hFFFFFFFF, 32'h00000000, 32'h2DFD1072);
    req("illegal_0f", 11'h00F, 32'h12345678, 32'h9ABCDEF0, 32'h00000000);
    req("illegal_10", 11'h010, 32'h12345678, 32'h9ABCDEF0, 32'h00000000);
    req("add_after_illegal", 11'h000, 32'd40, 32'd2, 32'd42);

    // Reset in the middle of a multiply: that request must never complete.
    user_valid     = 1'b1;
    user_opcode    = 11'h002;
    user_operand_0 = 32'hDEADBEEF;
    user_operand_1 = 32'hCAFEF00D;
    @(posedge clk); #1;
    user_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", user_result, 32'd0);
    check("midrun_reset_flags", {29'b0, user_complete, busy, illegal}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (user_complete) seen++;
    end
    check("midrun_no_complete", 32'(seen), 32'd0);
    check("midrun_idle", {31'b0, busy}, 32'd0);
    req("add_after_reset", 11'h000, 32'd2, 32'd3, 32'd5);

    // Randomized requests against the reference model
    for (int i = 0; i < 40; i++) begin
      op = {7'd0, 4'($urandom_range(0, 7))};
      if ($urandom_range(0, 7) == 0) op[10:4] = 7'($urandom_range(1, 127));
      a = $urandom;
      b = $urandom;
      req($sformatf("rand%0d", i), op, a, b, model_result(op, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
